// File: rtl/hub75_scan_driver_if.sv
// hub75_scan_driver_if
//   Bundles the frame-buffer read port and the HUB75 panel connector used by
//   hub75_scan_driver.
//   master : the scan driver (drives orow/ocol and all panel signals, reads o)
//   slave  : the memory/panel side (the mirror image)
//   Signals:
//     orow, ocol  frame-buffer read address
//     o           pixel word returned by the frame buffer
//     rgb         panel data {r,g,b}
//     sclk        panel shift clock
//     lat         panel latch strobe
//     oe_n        panel output enable, active low
//     addr        panel row select
//     frame_done  one-clock end-of-frame pulse
//     brightness  4-bit global brightness (only with HUB75_BRIGHTNESS_EN)
//   Optional feature macro: HUB75_BRIGHTNESS_EN

interface hub75_scan_driver_if #(
  parameter int ROWS    = 8,
  parameter int COLUMNS = 32,
  parameter int WIDTH   = 24
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;

  logic [RW-1:0]    orow;
  logic [CW-1:0]    ocol;
  logic [WIDTH-1:0] o;
  logic [2:0]       rgb;
  logic             sclk;
  logic             lat;
  logic             oe_n;
  logic [RW-1:0]    addr;
  logic             frame_done;

`ifdef HUB75_BRIGHTNESS_EN
  logic [3:0]       brightness;

  modport master (
    output orow, ocol, rgb, sclk, lat, oe_n, addr, frame_done,
    input  o, brightness
  );

  modport slave (
    input  orow, ocol, rgb, sclk, lat, oe_n, addr, frame_done,
    output o, brightness
  );
`else
  modport master (
    output orow, ocol, rgb, sclk, lat, oe_n, addr, frame_done,
    input  o
  );

  modport slave (
    input  orow, ocol, rgb, sclk, lat, oe_n, addr, frame_done,
    output o
  );
`endif

endinterface

// File: rtl/hub75_scan_driver.sv
// hub75_scan_driver
//   Walks the display frame buffer read port and serialises each pixel into
//   HUB75 shift-register signals. Brightness uses binary-code modulation:
//   every row is shifted DEPTH times, once per bit plane, and plane b is shown
//   for BASE_TIME<<b clocks. frame_done pulses during the final SHOW clock of
//   the last row/plane so the writer upstream can flip buffers.
//   Ports:
//     clk    system clock (same clock as the frame buffer)
//     rst_n  asynchronous active-low reset
//     bus    hub75_scan_driver_if.master (orow, ocol, o, rgb, sclk, lat,
//            oe_n, addr, frame_done, and brightness when enabled)
//   Optional feature macro: HUB75_BRIGHTNESS_EN
//     When defined, a 4-bit brightness value captured once per frame trims
//     the oe_n-low window inside every SHOW period without changing timing.

module hub75_scan_driver #(
  parameter int ROWS      = 8,
  parameter int COLUMNS   = 32,
  parameter int WIDTH     = 24,
  parameter int DEPTH     = 8,
  parameter int BASE_TIME = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  hub75_scan_driver_if.master bus
);

  localparam int RW       = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW       = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
  localparam int PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MAX_SHOW = BASE_TIME << (DEPTH - 1);
  localparam int TW       = $clog2(MAX_SHOW + 1);

  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(COLUMNS - 1);
  localparam logic [PW-1:0] PLANE_LAST = PW'(DEPTH - 1);
  localparam logic [2:0]    PH_SAMPLE  = 3'd2;
  localparam logic [2:0]    PH_LAST    = 3'd4;

  typedef enum logic [1:0] {
    SHIFT,
    LATCH,
    SHOW
  } state_t;

  state_t         state, state_n;
  logic [RW-1:0]  row, row_n;
  logic [CW-1:0]  col, col_n;
  logic [PW-1:0]  plane, plane_n;
  logic [2:0]     phase, phase_n;
  logic [TW-1:0]  show_cnt, show_cnt_n;
  logic [TW-1:0]  show_last;

  logic           sclk_d;
  logic           lat_d;
  logic           oe_n_d;
  logic           frame_done_d;
  logic           load_addr;
  logic           show_on;

  logic [RW-1:0]  orow_r;
  logic [CW-1:0]  ocol_r;
  logic [2:0]     rgb_r;
  logic           sclk_r;
  logic           lat_r;
  logic           oe_n_r;
  logic [RW-1:0]  addr_r;
  logic           frame_done_r;

  logic [DEPTH-1:0] r_ch;
  logic [DEPTH-1:0] g_ch;
  logic [DEPTH-1:0] b_ch;

  assign r_ch = bus.o[WIDTH-1 -: DEPTH];
  assign g_ch = bus.o[DEPTH +: DEPTH];
  assign b_ch = bus.o[0 +: DEPTH];

  // Plane does not change between LATCH and the end of SHOW, so the current
  // plane also describes any SHOW clock selected as the next state.
  assign show_last = TW'((32'(BASE_TIME) << plane) - 32'd1);

`ifdef HUB75_BRIGHTNESS_EN
  logic [3:0]  bright_q;
  logic [31:0] on_time;

  // Captured once at the very first SHIFT clock of the frame so the whole
  // frame is shown at a single brightness.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bright_q <= 4'hF;
    end else if (state == SHIFT && row == '0 && plane == '0 &&
                 col == '0 && phase == 3'd0) begin
      bright_q <= bus.brightness;
    end
  end

  assign on_time = ((32'(BASE_TIME) << plane) * (32'(bright_q) + 32'd1)) >> 4;
  assign show_on = (state_n == SHOW) && (32'(show_cnt_n) < on_time);
`else
  assign show_on = (state_n == SHOW);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SHIFT;
      row      <= '0;
      col      <= '0;
      plane    <= '0;
      phase    <= 3'd0;
      show_cnt <= '0;
    end else begin
      state    <= state_n;
      row      <= row_n;
      col      <= col_n;
      plane    <= plane_n;
      phase    <= phase_n;
      show_cnt <= show_cnt_n;
    end
  end

  // Panel outputs are decoded from the next state and registered, so every
  // pin changes cleanly on a clock edge and the reset values match the
  // SHIFT/ph0 state the block resets into.
  always_comb begin
    state_n      = state;
    row_n        = row;
    col_n        = col;
    plane_n      = plane;
    phase_n      = phase;
    show_cnt_n   = show_cnt;
    sclk_d       = 1'b0;
    lat_d        = 1'b0;
    oe_n_d       = 1'b1;
    frame_done_d = 1'b0;
    load_addr    = 1'b0;

    unique case (state)
      SHIFT: begin
        if (phase == PH_LAST) begin
          phase_n = 3'd0;
          if (col == COL_LAST) begin
            col_n   = '0;
            state_n = LATCH;
          end else begin
            col_n = col + 1'b1;
          end
        end else begin
          phase_n = phase + 3'd1;
        end
      end
      LATCH: begin
        state_n    = SHOW;
        show_cnt_n = '0;
      end
      SHOW: begin
        if (show_cnt == show_last) begin
          state_n    = SHIFT;
          show_cnt_n = '0;
          phase_n    = 3'd0;
          col_n      = '0;
          if (plane == PLANE_LAST) begin
            plane_n = '0;
            row_n   = (row == ROW_LAST) ? '0 : row + 1'b1;
          end else begin
            plane_n = plane + 1'b1;
          end
        end else begin
          show_cnt_n = show_cnt + 1'b1;
        end
      end
      default: begin
        state_n = SHIFT;
      end
    endcase

    sclk_d       = (state_n == SHIFT) && (phase_n == PH_LAST);
    lat_d        = (state_n == LATCH);
    oe_n_d       = !show_on;
    frame_done_d = (state_n == SHOW) && (show_cnt_n == show_last) &&
                   (row_n == ROW_LAST) && (plane_n == PLANE_LAST);
    load_addr    = (state_n == SHIFT) && (phase_n == 3'd0);
  end

  // The frame buffer only refreshes o every other clock, so the address is
  // held for ph0..ph2 and o is sampled at the end of ph2; rgb then stays
  // stable through ph3 before sclk rises in ph4.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      orow_r       <= '0;
      ocol_r       <= '0;
      rgb_r        <= 3'b000;
      sclk_r       <= 1'b0;
      lat_r        <= 1'b0;
      oe_n_r       <= 1'b1;
      addr_r       <= '0;
      frame_done_r <= 1'b0;
    end else begin
      sclk_r       <= sclk_d;
      lat_r        <= lat_d;
      oe_n_r       <= oe_n_d;
      frame_done_r <= frame_done_d;
      if (load_addr) begin
        orow_r <= row_n;
        ocol_r <= col_n;
      end
      if (state_n == LATCH) begin
        addr_r <= row;
      end
      if (state == SHIFT && phase == PH_SAMPLE) begin
        rgb_r <= {r_ch[plane], g_ch[plane], b_ch[plane]};
      end
    end
  end

  assign bus.orow       = orow_r;
  assign bus.ocol       = ocol_r;
  assign bus.rgb        = rgb_r;
  assign bus.sclk       = sclk_r;
  assign bus.lat        = lat_r;
  assign bus.oe_n       = oe_n_r;
  assign bus.addr       = addr_r;
  assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_hub75_scan_driver.sv
// tb_hub75_scan_driver
//   Scoreboard bench for hub75_scan_driver with ROWS=2, COLUMNS=4, WIDTH=6,
//   DEPTH=2, BASE_TIME=2. A small frame-buffer model refreshes o every other
//   clock at a selectable alignment. Expected panel events (sclk rises with
//   rgb, latch pulses with addr, oe_n-low windows, row changes, frame_done)
//   are queued when a run starts; a monitor pops and compares them as the
//   DUT produces them. "Clock N" is the interval just before the Nth rising
//   edge after rst_n release, sampled on the falling edge.
//   Optional feature macro: HUB75_BRIGHTNESS_EN (driven to full scale here).

module tb_hub75_scan_driver;

  localparam int ROWS      = 2;
  localparam int COLUMNS   = 4;
  localparam int WIDTH     = 6;
  localparam int DEPTH     = 2;
  localparam int BASE_TIME = 2;
  localparam int FULL_RUN  = 194;
  localparam int DROP_RUN  = 46;

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  logic clk;
  logic rst_n;

  hub75_scan_driver_if #(.ROWS(ROWS), .COLUMNS(COLUMNS), .WIDTH(WIDTH)) bus ();

  hub75_scan_driver #(
    .ROWS(ROWS), .COLUMNS(COLUMNS), .WIDTH(WIDTH),
    .DEPTH(DEPTH), .BASE_TIME(BASE_TIME)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

`ifdef HUB75_BRIGHTNESS_EN
  assign bus.brightness = 4'hF;
`endif

  // Frame buffer contents, column 0 first; r=[5:4], g=[3:2], b=[1:0].
  logic [5:0] mem [2][4] = '{
    '{6'b001001, 6'b010010, 6'b100100, 6'b111111},
    '{6'b101010, 6'b010101, 6'b110000, 6'b000011}
  };

  // Hand-derived {r,g,b} plane bits: rgb_tab[row][plane][col].
  logic [2:0] rgb_tab [2][2][4] = '{
    '{'{3'b001, 3'b100, 3'b010, 3'b111},
      '{3'b010, 3'b001, 3'b100, 3'b111}},
    '{'{3'b000, 3'b111, 3'b100, 3'b001},
      '{3'b111, 3'b000, 3'b100, 3'b001}}
  };

  logic [5:0] mem_o;
  logic       mem_tick;
  logic       mem_phase;
  logic       mon_en;

  int n_checks;
  int n_errors;

  ev_t rgb_q[$];
  ev_t lat_q[$];
  ev_t oe_q[$];
  ev_t row_q[$];
  ev_t fd_q[$];

  assign bus.o = mem_o;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Frame-buffer model: refresh every other edge, alignment set by mem_phase.
  always @(posedge clk) begin
    if (!rst_n) begin
      mem_tick <= mem_phase;
    end else begin
      mem_tick <= ~mem_tick;
    end
    if (mem_tick) begin
      mem_o <= mem[bus.orow][bus.ocol];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic pushExpected(input int limit);
    ev_t e;
    int base;
    rgb_q.delete();
    lat_q.delete();
    oe_q.delete();
    row_q.delete();
    fd_q.delete();
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < 2; r++) begin
        for (int p = 0; p < 2; p++) begin
          base = 96 * f + 48 * r + 23 * p;
          for (int c = 0; c < 4; c++) begin
            e.cyc = base + 4 + 5 * c;
            e.val = int'(rgb_tab[r][p][c]);
            if (e.cyc < limit) rgb_q.push_back(e);
          end
          e.cyc = base + 20;
          e.val = r;
          if (e.cyc < limit) lat_q.push_back(e);
          e.cyc = base + 21;
          e.val = 2 << p;
          if (e.cyc + e.val < limit) oe_q.push_back(e);
        end
      end
      e.cyc = 96 * f + 95;
      e.val = 1;
      if (e.cyc < limit) fd_q.push_back(e);
    end
    for (int k = 1; k <= 4; k++) begin
      e.cyc = 48 * k;
      e.val = k % 2;
      if (e.cyc < limit) row_q.push_back(e);
    end
  endtask

  // Monitor: pops the next expected event whenever the DUT presents one.
  initial begin : monitor
    int   cyc;
    int   low_start;
    int   low_len;
    bit   in_low;
    logic last_orow;
    ev_t  e;
    cyc = 0; low_start = 0; low_len = 0; in_low = 0; last_orow = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        cyc = 0; low_len = 0; in_low = 0; last_orow = 1'b0;
      end else begin
        if (cyc == 0) begin
          checkOutput("orow_clk0", 32'(bus.orow), 0);
          checkOutput("ocol_clk0", 32'(bus.ocol), 0);
        end
        if (bus.sclk === 1'b1) begin
          if (rgb_q.size() == 0) checkOutput("unexpected_sclk_at", cyc, -1);
          else begin
            e = rgb_q.pop_front();
            checkOutput("sclk_clock", cyc, e.cyc);
            checkOutput("rgb", 32'(bus.rgb), e.val);
          end
        end
        if (bus.lat === 1'b1) begin
          if (lat_q.size() == 0) checkOutput("unexpected_lat_at", cyc, -1);
          else begin
            e = lat_q.pop_front();
            checkOutput("lat_clock", cyc, e.cyc);
            checkOutput("addr_at_lat", 32'(bus.addr), e.val);
          end
        end
        if (bus.oe_n === 1'b0) begin
          if (!in_low) begin
            in_low = 1;
            low_start = cyc;
            low_len = 0;
          end
          low_len++;
        end else if (in_low) begin
          in_low = 0;
          if (oe_q.size() == 0) checkOutput("unexpected_oe_low_at", low_start, -1);
          else begin
            e = oe_q.pop_front();
            checkOutput("oe_low_start", low_start, e.cyc);
            checkOutput("oe_low_len", low_len, e.val);
          end
        end
        if (bus.frame_done === 1'b1) begin
          if (fd_q.size() == 0) checkOutput("unexpected_frame_done_at", cyc, -1);
          else begin
            e = fd_q.pop_front();
            checkOutput("frame_done_clock", cyc, e.cyc);
          end
        end
        if (bus.orow !== last_orow) begin
          if (row_q.size() == 0) checkOutput("unexpected_orow_change_at", cyc, -1);
          else begin
            e = row_q.pop_front();
            checkOutput("orow_change_clock", cyc, e.cyc);
            checkOutput("orow_value", 32'(bus.orow), e.val);
          end
          last_orow = bus.orow;
        end
        cyc++;
      end
    end
  end

  // One run: hold reset, check reset outputs, queue expectations, release,
  // then either run to completion or drop rst_n during plane-1 SHOW.
  task automatic applyStimulus(input logic phase, input int ncyc,
                               input bit drop_mid);
    rst_n     = 1'b0;
    mon_en    = 1'b0;
    mem_phase = phase;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("rst_oe_n", 32'(bus.oe_n), 1);
    checkOutput("rst_lat", 32'(bus.lat), 0);
    checkOutput("rst_sclk", 32'(bus.sclk), 0);
    checkOutput("rst_rgb", 32'(bus.rgb), 0);
    checkOutput("rst_addr", 32'(bus.addr), 0);
    checkOutput("rst_orow", 32'(bus.orow), 0);
    checkOutput("rst_ocol", 32'(bus.ocol), 0);
    checkOutput("rst_frame_done", 32'(bus.frame_done), 0);
    pushExpected(ncyc);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (ncyc) @(negedge clk);
    #1;
    if (drop_mid) begin
      checkOutput("oe_n_in_show_before_drop", 32'(bus.oe_n), 0);
      rst_n = 1'b0;
      #1;
      checkOutput("oe_n_async_reset", 32'(bus.oe_n), 1);
    end
    mon_en = 1'b0;
    checkOutput("rgb_events_left", rgb_q.size(), 0);
    checkOutput("lat_events_left", lat_q.size(), 0);
    checkOutput("oe_events_left", oe_q.size(), 0);
    checkOutput("orow_events_left", row_q.size(), 0);
    checkOutput("frame_done_events_left", fd_q.size(), 0);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    mon_en    = 1'b0;
    mem_phase = 1'b0;
    mem_o     = '0;
    mem_tick  = 1'b0;
    $display("[TB] run 1: full frame pair, memory refresh even alignment");
    applyStimulus(1'b0, FULL_RUN, 1'b0);
    $display("[TB] run 2: full frame pair, memory refresh odd alignment");
    applyStimulus(1'b1, FULL_RUN, 1'b0);
    $display("[TB] run 3: async reset dropped at clock 45");
    applyStimulus(1'b0, DROP_RUN, 1'b1);
    $display("[TB] run 4: restart after async reset");
    applyStimulus(1'b1, FULL_RUN, 1'b0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
